ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
Parametrised multiply/divide and HI/LO execution unit, the successor to the single-cycle EX ALU path. Sits beside the ALU in EX. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the instruction held in EX and owns the architectural HI/LO registers. Raises stall_req while a multi-cycle operation is in flight, so the pipeline control freezes IF..EX.

Parameters:
W, 32, datapath width (even, >=8)
MUL_LAT, 2, multiply latency in cycles, legal 1..4
Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  cancel any in-flight op (exception/redirect)
pipe_stall  in  1  downstream stall; EX instruction is being held
start  in  1  EX holds a valid md op this cycle
op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none
src_a  in  W  rs operand, already forwarded
src_b  in  W  rt operand, already forwarded
stall_req  out  1  hold pipeline; combinational
busy  out  1  state != IDLE; registered
hi_o  out  W  committed HI; registered
lo_o  out  W  committed LO; registered

Behaviour:
- Reset: state IDLE, hi_o=lo_o=0, busy=0, stall_req=0, counters and operand registers 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE + start + MTHI/MTLO: hi_o/lo_o <= src_a at the edge. No stall. Stay in IDLE.
- IDLE + start + MULT/MULTU: capture operands, go to MUL.
  - 2W-bit product computed (signed for MULT).
  - At the edge ending cycle MUL_LAT-1 (cycle 0 = accept cycle): hi_o <= product[2W-1:W], lo_o <= product[W-1:0]; go to DONE.
- IDLE + start + DIV/DIVU: capture operands, go to DIV.
  - Restoring divide on magnitudes, one quotient bit per cycle.
  - Sign fix applied in the final cycle.
  - HI/LO written at the edge ending cycle W; go to DONE.
- stall_req = (IDLE & start & op in {MULT,MULTU,DIV,DIVU} & !flush) | state==MUL | state==DIV.
  - Multiply stalls exactly MUL_LAT cycles.
  - Divide stalls exactly W+1 cycles.
- DONE:
  - stall_req=0; start is ignored, so the held instruction is not re-executed.
  - Go to IDLE on the first cycle with pipe_stall=0.
  - Stay in DONE while pipe_stall=1.
- Signed divide rules:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - MIN / -1 gives LO=MIN, HI=0.
- Divide by zero (both DIV and DIVU): LO = all ones, HI = src_a raw. Full W+1 latency still applies.
- flush:
  - Highest priority, any state.
  - Next state is IDLE, busy=0 next cycle.
  - HI/LO are not written by the cancelled op.
  - An MTHI/MTLO in the same cycle as flush is dropped.
  - stall_req is 0 in the flush cycle.
- HI/LO are written only by completion or MTHI/MTLO. hi_o/lo_o show the new value the cycle after the write edge. MFHI/MFLO read hi_o/lo_o.
- rst mid-operation: same effect as the reset values above. Product/quotient pipeline contents are discarded.
- op 000/111 with start: no effect.

Test Plan:
- MULT, a=0xFFFFFFFD (-3), b=5, MUL_LAT=2 -> stall_req high 2 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy=0 one cycle after DONE.
- DIVU 100/7 -> stall_req high exactly 33 cycles; LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 0x12345678/0 -> LO=0xFFFFFFFF, HI=0x12345678 after 33 stall cycles.
- DIV started with HI=LO=0xAA; flush in cycle 10 -> stall_req 0 in that cycle; busy=0 next cycle; HI=LO=0xAA unchanged.
- MULTU completes, then pipe_stall=1 and start held for 3 cycles -> remains in DONE; no second write, no stall_req; IDLE after pipe_stall falls.
- MTHI 0x1 then MTLO 0x2 on consecutive cycles -> no stall; hi_o=1, lo_o=2 one cycle after each. rst during MUL -> HI=LO=0, IDLE.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multiply/divide and HI/LO unit for the EX stage.
// Owns the architectural HI/LO registers. Multiplies complete after MUL_LAT
// cycles. Divides use a restoring algorithm and complete after W+1 cycles.
// While either is in flight, stall_req freezes IF..EX.
module ex_muldiv_unit #(
    parameter int W       = 32,
    parameter int MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         pipe_stall,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    output logic         stall_req,
    output logic         busy,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    // The counter must reach W for divides and MUL_LAT-1 for multiplies.
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CW-1:0]     r_cnt;
    logic [W-1:0]      r_hi;
    logic [W-1:0]      r_lo;
    logic [2*W-1:0]    r_prod_p1;
    logic [W-1:0]      r_a_raw;
    logic [W-1:0]      r_rem;
    logic [W-1:0]      r_quo;
    logic [W-1:0]      r_dvs;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_dbz;

    logic              w_is_mul;
    logic              w_is_div;
    logic              w_is_sgn;
    logic              w_in_idle;
    logic              w_mul_last;
    logic              w_div_last;
    logic [2*W-1:0]    w_prod_p0;
    logic [W:0]        w_rem_sh;
    logic [W:0]        w_diff;
    logic              w_ge;
    logic [W-1:0]      w_rem_nxt;
    logic [W-1:0]      w_quo_nxt;
    logic [W-1:0]      w_q_fix;
    logic [W-1:0]      w_r_fix;

    // Full 2W-bit product. Each operand gets one extra bit so that a single
    // signed multiplier serves both the signed and the unsigned forms.
    function automatic logic [2*W-1:0] mul_full(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic         sgn);
        logic signed [W:0]     ea;
        logic signed [W:0]     eb;
        logic signed [2*W+1:0] p;
        ea = {sgn & a[W-1], a};
        eb = {sgn & b[W-1], b};
        p  = ea * eb;
        return p[2*W-1:0];
    endfunction

    // Magnitude of an operand. MIN maps to itself, which equals 2^(W-1)
    // when read as unsigned.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
        return (sgn & x[W-1]) ? (~x + 1'b1) : x;
    endfunction

    // Conditional two's-complement negate, used for the final sign fix.
    function automatic logic [W-1:0] neg_if(input logic [W-1:0] x, input logic c);
        return c ? (~x + 1'b1) : x;
    endfunction

    assign w_in_idle  = (r_state == S_IDLE);
    assign w_is_mul   = start & ((op == OP_MULT) | (op == OP_MULTU));
    assign w_is_div   = start & ((op == OP_DIV)  | (op == OP_DIVU));
    assign w_is_sgn   = (op == OP_MULT) | (op == OP_DIV);
    assign w_mul_last = (r_cnt == CW'(MUL_LAT - 1));
    assign w_div_last = (r_cnt == CW'(W));

    assign w_prod_p0  = mul_full(src_a, src_b, w_is_sgn);

    // One restoring step: shift the next dividend bit in, then subtract if the result fits.
    assign w_rem_sh   = {r_rem, r_quo[W-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_dvs};
    assign w_ge       = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_nxt  = w_ge ? w_diff[W-1:0] : w_rem_sh[W-1:0];
    assign w_quo_nxt  = {r_quo[W-2:0], w_ge};

    // A divide by zero overrides the sign fix: LO is all ones and HI is the raw dividend.
    assign w_q_fix    = r_dbz ? {W{1'b1}} : neg_if(w_quo_nxt, r_neg_q);
    assign w_r_fix    = r_dbz ? r_a_raw   : neg_if(w_rem_nxt, r_neg_r);

    assign stall_req  = ~flush & ((w_in_idle & (w_is_mul | w_is_div)) |
                                  (r_state == S_MUL) | (r_state == S_DIV));
    assign busy       = (r_state != S_IDLE);
    assign hi_o       = r_hi;
    assign lo_o       = r_lo;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. A flush always returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_is_mul) begin
                    w_state_nxt = (MUL_LAT == 1) ? S_DONE : S_MUL;
                end else if (w_is_div) begin
                    w_state_nxt = S_DIV;
                end
            end
            S_MUL:  if (w_mul_last) w_state_nxt = S_DONE;
            S_DIV:  if (w_div_last) w_state_nxt = S_DONE;
            S_DONE: if (!pipe_stall) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Datapath. Captures operands on accept, steps the product or divider,
    // and writes HI/LO on completion or on MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_prod_p1 <= '0;
            r_a_raw   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dbz     <= 1'b0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (start && op == OP_MTHI) r_hi <= src_a;
                    if (start && op == OP_MTLO) r_lo <= src_a;
                    if (w_is_mul) begin
                        r_cnt   <= CW'(1);
                        r_a_raw <= src_a;
                        if (MUL_LAT == 1) begin
                            r_hi <= w_prod_p0[2*W-1:W];
                            r_lo <= w_prod_p0[W-1:0];
                        end else begin
                            r_prod_p1 <= w_prod_p0;
                        end
                    end
                    if (w_is_div) begin
                        r_cnt   <= CW'(1);
                        r_a_raw <= src_a;
                        r_rem   <= '0;
                        r_quo   <= mag(src_a, w_is_sgn);
                        r_dvs   <= mag(src_b, w_is_sgn);
                        r_neg_q <= w_is_sgn & (src_a[W-1] ^ src_b[W-1]);
                        r_neg_r <= w_is_sgn & src_a[W-1];
                        r_dbz   <= (src_b == '0);
                    end
                end
                S_MUL: begin
                    if (w_mul_last) begin
                        r_hi <= r_prod_p1[2*W-1:W];
                        r_lo <= r_prod_p1[W-1:0];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DIV: begin
                    if (w_div_last) begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for ex_muldiv_unit (W=32, MUL_LAT=2).
module tb_ex_muldiv_unit;

    localparam int W       = 32;
    localparam int MUL_LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         pipe_stall;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         stall_req;
    logic         busy;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    ex_muldiv_unit #(.W(W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .flush(flush), .pipe_stall(pipe_stall),
        .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .stall_req(stall_req), .busy(busy), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference results packed as {HI, LO}.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0] ua, ub, uq, ur;
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd1: begin sp = sa * sb; return sp; end
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one mul/div op, hold it in EX while stalled, then check stall length and result.
    task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        int nst;
        int exp_st;
        logic [63:0] e;
        exp_st = (o == 3'd1 || o == 3'd2) ? MUL_LAT : W + 1;
        sb_q.push_back(model(o, a, b));
        start = 1'b1; op = o; src_a = a; src_b = b;
        nst = 0;
        @(negedge clk);
        while (stall_req === 1'b1 && nst < 200) begin
            nst++;
            @(negedge clk);
        end
        check({tag, "_stall"}, 64'(nst), 64'(exp_st));
        check({tag, "_busy_done"}, 64'(busy), 64'd1);
        e = sb_q.pop_front();
        check({tag, "_hi"}, 64'(hi_o), 64'(e[63:32]));
        check({tag, "_lo"}, 64'(lo_o), 64'(e[31:0]));
        next_cycle();
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        check({tag, "_busy_idle"}, 64'(busy), 64'd0);
        next_cycle();
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] e;
        rst = 1'b1; flush = 1'b0; pipe_stall = 1'b0; start = 1'b0;
        op = 3'd0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        next_cycle();

        run_md("mult_neg3x5", 3'd1, 32'hFFFFFFFD, 32'd5);
        run_md("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_md("divu_100_7", 3'd4, 32'd100, 32'd7);
        run_md("div_neg7_2", 3'd3, 32'hFFFFFFF9, 32'd2);
        run_md("div_min_m1", 3'd3, 32'h80000000, 32'hFFFFFFFF);
        run_md("divu_by0", 3'd4, 32'h12345678, 32'd0);
        run_md("div_by0", 3'd3, 32'hFFFFFFFB, 32'd0);
        run_md("div_7_neg2", 3'd3, 32'd7, 32'hFFFFFFFE);

        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(1, 4));
            ra = $urandom();
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom();
            run_md("rand", ro, ra, rb);
        end

        // MTHI then MTLO on consecutive cycles.
        start = 1'b1; op = 3'd5; src_a = 32'h1;
        @(negedge clk);
        check("mthi_stall", 64'(stall_req), 64'd0);
        next_cycle();
        op = 3'd6; src_a = 32'h2;
        @(negedge clk);
        check("mtlo_stall", 64'(stall_req), 64'd0);
        check("mthi_hi", 64'(hi_o), 64'd1);
        next_cycle();
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        check("mtlo_lo", 64'(lo_o), 64'd2);
        check("mtlo_hi_kept", 64'(hi_o), 64'd1);
        next_cycle();

        // An MTHI issued together with flush is dropped.
        start = 1'b1; op = 3'd5; src_a = 32'h55; flush = 1'b1;
        next_cycle();
        start = 1'b0; op = 3'd0; flush = 1'b0;
        @(negedge clk);
        check("mthi_flush_hi", 64'(hi_o), 64'd1);
        next_cycle();

        // op 000 and 111 with start have no effect.
        start = 1'b1; op = 3'd0; src_a = 32'h77;
        @(negedge clk);
        check("op0_stall", 64'(stall_req), 64'd0);
        next_cycle();
        op = 3'd7;
        @(negedge clk);
        check("op7_stall", 64'(stall_req), 64'd0);
        next_cycle();
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        check("op7_hi", 64'(hi_o), 64'd1);
        check("op7_lo", 64'(lo_o), 64'd2);
        check("op7_busy", 64'(busy), 64'd0);
        next_cycle();

        // DIV cancelled by flush in cycle 10 leaves HI/LO untouched.
        start = 1'b1; op = 3'd5; src_a = 32'hAA;
        next_cycle();
        op = 3'd6;
        next_cycle();
        op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_stall", 64'(stall_req), 64'd0);
        next_cycle();
        flush = 1'b0; start = 1'b0; op = 3'd0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("flush_hi", 64'(hi_o), 64'hAA);
        check("flush_lo", 64'(lo_o), 64'hAA);
        next_cycle();

        // MULTU finishing under pipe_stall holds in DONE without re-executing.
        e = model(3'd2, 32'h00010003, 32'h00020005);
        sb_q.push_back(e);
        pipe_stall = 1'b1; start = 1'b1; op = 3'd2; src_a = 32'h00010003; src_b = 32'h00020005;
        repeat (MUL_LAT) next_cycle();
        e = sb_q.pop_front();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_stall", 64'(stall_req), 64'd0);
            check("hold_busy", 64'(busy), 64'd1);
            check("hold_hilo", {hi_o, lo_o}, e);
            next_cycle();
        end
        pipe_stall = 1'b0;
        @(negedge clk);
        check("hold_release_busy", 64'(busy), 64'd1);
        next_cycle();
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        check("hold_idle_busy", 64'(busy), 64'd0);
        check("hold_hilo_final", {hi_o, lo_o}, e);
        next_cycle();

        // Reset in the middle of a multiply.
        start = 1'b1; op = 3'd1; src_a = 32'd9; src_b = 32'd9;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; start = 1'b0; op = 3'd0;
        @(negedge clk);
        check("rstmul_hi", 64'(hi_o), 64'd0);
        check("rstmul_lo", 64'(lo_o), 64'd0);
        check("rstmul_busy", 64'(busy), 64'd0);
        check("rstmul_stall", 64'(stall_req), 64'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rstmul_lo_later", 64'(lo_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
